wb_stream_checker: RTL

- Synthesizable self-checking monitor on the core's writeback stage.
- Holds a loadable table of expected (register, data) writebacks and compares every retiring register write against it, in order.
- Reports pass, first mismatch or timeout with cycle and match counts.
- Instantiated beside the core in benches and FPGA bring-up, so program correctness is judged in hardware rather than by waveform inspection.

---
 rtl/wb_chk_pkg.sv | 19 +
 rtl/wb_chk_table.sv | 21 ++
 rtl/wb_stream_checker.sv | 101 ++++++++++
 3 files changed

// File: rtl/wb_chk_pkg.sv
// wb_chk_pkg: shared state encoding, table entry layout and sizing helper for the writeback checker
package wb_chk_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        PASS = 3'd2,
        FAIL = 3'd3,
        TOUT = 3'd4
    } state_t;
    localparam int REG_AW_DEF = 5;
    localparam int DATA_W_DEF = 32;
    typedef struct packed {
        logic [REG_AW_DEF-1:0] reg_addr;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;
    function automatic int idx_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/wb_chk_table.sv
// wb_chk_table: expected-writeback table, synchronous write, asynchronous read, no reset
module wb_chk_table #(
    parameter int DEPTH  = 16,
    parameter int REG_AW = 5,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [REG_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [REG_AW+DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[widx] <= {waddr, wdata};
    assign {raddr, rdata} = mem[ridx];
endmodule

// File: rtl/wb_stream_checker.sv
// wb_stream_checker: compares retiring register writes in order against a loaded table and
// reports pass, first mismatch or timeout together with cycle and match counts
module wb_stream_checker import wb_chk_pkg::*; #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int DEPTH     = 16,
    parameter int IDX_W     = idx_w(DEPTH),
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1024,
    parameter int IGNORE_R0 = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [REG_AW-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [IDX_W:0]    n_exp,
    input  logic              start,
    input  logic              reg_write_wb,
    input  logic [REG_AW-1:0] dst_addr_wb,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              tout,
    output logic [IDX_W-1:0]  err_idx,
    output logic [REG_AW-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [IDX_W:0]    match_cnt
);
    state_t state, state_d;
    logic [IDX_W:0] n_lat;
    logic [REG_AW-1:0] t_addr;
    logic [DATA_W-1:0] t_data;
    logic qual, hit, miss, last, tmo;

    wb_chk_table #(.DEPTH(DEPTH), .REG_AW(REG_AW), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_table (
        .clk(clk),
        .we(exp_we && state == IDLE),
        .widx(exp_idx),
        .waddr(exp_addr),
        .wdata(exp_data),
        .ridx(match_cnt[IDX_W-1:0]),
        .raddr(t_addr),
        .rdata(t_data)
    );

    assign qual = reg_write_wb && !(IGNORE_R0 != 0 && dst_addr_wb == '0);
    assign hit  = qual && t_addr == dst_addr_wb && t_data == wb_data;
    assign miss = qual && !hit;
    assign last = match_cnt + 1'b1 == n_lat;
    assign tmo  = cycle_cnt == CNT_W'(TIMEOUT - 1);

    always_comb begin
        state_d = state;
        if (state == RUN)
            state_d = miss ? FAIL : (hit && last) ? PASS : tmo ? TOUT : RUN;
        else if (start)
            state_d = n_exp == '0 ? PASS : RUN;
    end

    // status flags are decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            {busy, done, pass, fail, tout} <= '0;
            n_lat     <= '0;
            cycle_cnt <= '0;
            match_cnt <= '0;
            err_idx   <= '0;
            err_addr  <= '0;
            err_data  <= '0;
        end else begin
            state <= state_d;
            busy  <= state_d == RUN;
            done  <= state_d == PASS || state_d == FAIL || state_d == TOUT;
            pass  <= state_d == PASS;
            fail  <= state_d == FAIL;
            tout  <= state_d == TOUT;
            if (state == RUN) begin
                cycle_cnt <= cycle_cnt + 1'b1;
                if (hit) match_cnt <= match_cnt + 1'b1;
                if (miss) begin
                    err_idx  <= match_cnt[IDX_W-1:0];
                    err_addr <= dst_addr_wb;
                    err_data <= wb_data;
                end
            end else if (start) begin
                n_lat     <= n_exp;
                cycle_cnt <= '0;
                match_cnt <= '0;
                err_idx   <= '0;
                err_addr  <= '0;
                err_data  <= '0;
            end
        end
    end
endmodule
